// File: rtl/mul_pkg.sv
// Shared types and sizing for the iterative RV32M multiplier.
// Op encoding equals funct3[1:0] so decode can pass it straight through.
package mul_pkg;

    localparam int XLEN = 32;
    localparam int ITER = 32;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } mul_state_e;

endpackage

// File: rtl/mul_unit_fa_32bit.sv
// 32-bit adder with carry-out; the single accumulate datapath of mul_unit.
module FA_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'b0, cin};

endmodule

// File: rtl/mul_unit.sv
// Radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Multiplies operand magnitudes, then restores the sign in a single fix cycle.
//
// state | meaning
// IDLE  | waiting for i_start, operands latched on start
// CALC  | 32 shift-add iterations through FA_32bit
// FIX   | conditional 64-bit negate, register o_result
// DONE  | o_done pulse, result valid
module mul_unit
    import mul_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_result
);

    mul_state_e state, next_state;
    mul_op_e    op_q;
    logic [XLEN-1:0]   mcand;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;
    logic              neg;
    logic [4:0]        cnt;

    logic        sgn1, sgn2;
    logic [31:0] mag1, mag2;
    logic [31:0] add_b, add_sum;
    logic        add_c;

    // Only operands that are signed for this op contribute a sign.
    assign sgn1 = ((i_op == MULH) || (i_op == MULHSU)) && i_rs1[31];
    assign sgn2 = (i_op == MULH) && i_rs2[31];
    assign mag1 = sgn1 ? (32'd0 - i_rs1) : i_rs1;
    assign mag2 = sgn2 ? (32'd0 - i_rs2) : i_rs2;

    assign add_b    = prod[0] ? mcand : 32'd0;
    assign prod_fix = neg ? (~prod + 64'd1) : prod;

    FA_32bit u_fa (
        .a    (prod[63:32]),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_c)
    );

    always_comb begin
        next_state = state;
        o_busy     = 1'b1;
        o_done     = 1'b0;
        case (state)
            IDLE: begin
                o_busy = 1'b0;
                if (i_start) next_state = CALC;
            end
            CALC: if (cnt == 5'(ITER - 1)) next_state = FIX;
            FIX:  next_state = DONE;
            DONE: begin
                o_done     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state    <= IDLE;
            op_q     <= MUL;
            mcand    <= '0;
            prod     <= '0;
            neg      <= 1'b0;
            cnt      <= '0;
            o_result <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: if (i_start) begin
                    op_q  <= mul_op_e'(i_op);
                    mcand <= mag1;
                    neg   <= sgn1 ^ sgn2;
                    prod  <= {32'd0, mag2};
                    cnt   <= '0;
                end
                CALC: begin
                    prod <= {add_c, add_sum, prod[31:1]};
                    cnt  <= cnt + 5'd1;
                end
                FIX: begin
                    prod     <= prod_fix;
                    o_result <= (op_q == MUL) ? prod_fix[31:0] : prod_fix[63:32];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed table, random vectors against
// a 64-bit arithmetic reference, and hand-written control sequences.
module tb_mul_unit;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [1:0]  i_op;
    logic [31:0] i_rs1;
    logic [31:0] i_rs2;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_result;

    int tests = 0;
    int fails = 0;

    mul_unit dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_start  (i_start),
        .i_op     (i_op),
        .i_rs1    (i_rs1),
        .i_rs2    (i_rs2),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_result (o_result)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        sa = (op == 2'b01 || op == 2'b10) ? longint'($signed(a)) : longint'({32'd0, a});
        sb = (op == 2'b01) ? longint'($signed(b)) : longint'({32'd0, b});
        p  = sa * sb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Issue one op from IDLE and run to completion; reports latency of o_done
    // (edges after the start edge), busy cycle count and done pulse count.
    // If pulse_at > 0, i_start is pulsed with junk operands that many edges in.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int pulse_at,
                          output logic [31:0] res, output int lat, output int busy_cyc,
                          output int done_cnt);
        lat = -1; busy_cyc = 0; done_cnt = 0; res = 'x;
        @(negedge i_clk);
        i_start = 1'b1; i_op = op; i_rs1 = a; i_rs2 = b;
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
        i_rs1 = $urandom; i_rs2 = $urandom; i_op = 2'($urandom);
        if (o_busy) busy_cyc++;
        for (int k = 1; k <= 40; k++) begin
            if (k == pulse_at) i_start = 1'b1;
            @(posedge i_clk);
            @(negedge i_clk);
            i_start = 1'b0;
            if (o_busy) busy_cyc++;
            if (o_done) begin
                done_cnt++;
                lat = k;
                res = o_result;
            end
            if (!o_busy) break;
        end
    endtask

    initial begin
        logic [31:0] res, exp;
        int lat, busy_cyc, done_cnt;

        vecs[0] = '{2'b00, 32'd7,          32'd6,          32'h0000002A};
        vecs[1] = '{2'b00, 32'hFFFFFFFD,   32'd5,          32'hFFFFFFF1};
        vecs[2] = '{2'b01, 32'hFFFFFFFD,   32'd5,          32'hFFFFFFFF};
        vecs[3] = '{2'b01, 32'h80000000,   32'h80000000,   32'h40000000};
        vecs[4] = '{2'b00, 32'h80000000,   32'h80000000,   32'h00000000};
        vecs[5] = '{2'b11, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE};
        vecs[6] = '{2'b10, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF};
        vecs[7] = '{2'b01, 32'h00000000,   32'h80000000,   32'h00000000};

        i_reset = 1'b0; i_start = 1'b0; i_op = 2'b00; i_rs1 = '0; i_rs2 = '0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("reset_busy",   {31'd0, o_busy}, 32'd0);
        check("reset_done",   {31'd0, o_done}, 32'd0);
        check("reset_result", o_result,        32'd0);
        i_reset = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, res, lat, busy_cyc, done_cnt);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd33);
            check($sformatf("vec%0d_busy", i), 32'(busy_cyc), 32'd34);
            check($sformatf("vec%0d_donecnt", i), 32'(done_cnt), 32'd1);
            check($sformatf("vec%0d_hold", i), o_result, vecs[i].exp);
        end

        for (int i = 0; i < 24; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            op = 2'($urandom);
            a  = $urandom;
            b  = $urandom;
            if (i % 6 == 0) a = {a[31], 31'd0};
            if (i % 6 == 1) b = 32'hFFFFFFFF;
            exp = ref_mul(op, a, b);
            run_op(op, a, b, 0, res, lat, busy_cyc, done_cnt);
            check($sformatf("rand%0d_op%0d_%h_%h", i, op, a, b), res, exp);
            check($sformatf("rand%0d_latency", i), 32'(lat), 32'd33);
        end

        // Start pulsed mid-CALC must be ignored, and not queued afterwards.
        run_op(2'b00, 32'd1234, 32'd5678, 5, res, lat, busy_cyc, done_cnt);
        check("ignore_start_result",  res, 32'd7006652);
        check("ignore_start_latency", 32'(lat), 32'd33);
        check("ignore_start_donecnt", 32'(done_cnt), 32'd1);
        repeat (3) @(negedge i_clk);
        check("ignore_start_noqueue", {31'd0, o_busy}, 32'd0);

        // Reset during iteration 10 abandons the op.
        @(negedge i_clk);
        i_start = 1'b1; i_op = 2'b11; i_rs1 = 32'd99; i_rs2 = 32'd77;
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (10) @(posedge i_clk);
        @(negedge i_clk);
        check("midrst_busy_before", {31'd0, o_busy}, 32'd1);
        i_reset = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        check("midrst_busy",   {31'd0, o_busy}, 32'd0);
        check("midrst_result", o_result,        32'd0);
        check("midrst_done",   {31'd0, o_done}, 32'd0);
        i_reset = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge i_clk);
            if (o_done || o_busy) done_cnt++;
        end
        check("midrst_no_done", 32'(done_cnt), 32'd0);

        run_op(2'b11, 32'd3, 32'd4, 0, res, lat, busy_cyc, done_cnt);
        check("fresh_mulhu_result",  res, 32'd0);
        check("fresh_mulhu_latency", 32'(lat), 32'd33);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mul_unit.md
# mul_unit

Iterative radix-2 shift-add multiplier implementing the RV32M multiply group (MUL, MULH, MULHSU, MULHU). Sits in the execute stage beside the ALU and consumes the team's 32-bit ripple adder (FA_32bit) as its single accumulate datapath. Each operation takes 32 accumulate iterations plus one sign-fix cycle. The core stalls on o_busy and writes back o_result when o_done pulses.

## Interface
- Parameters: none; datapath fixed at 32 bits, matching FA_32bit.
- i_clk  in  1  system clock, rising-edge.
- i_reset  in  1  synchronous, active-low reset.
- i_start  in  1  request; sampled only in IDLE.
- i_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (equals funct3[1:0]).
- i_rs1  in  32  multiplicand; signed for MULH and MULHSU.
- i_rs2  in  32  multiplier; signed for MULH only.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse while in DONE.
- o_result  out  32  registered result; holds until the next completion.

## Operation
- States:
  - IDLE: wait for i_start; go to CALC when i_start=1.
  - CALC: 32 iterations, then go to FIX.
  - FIX: one cycle, then go to DONE.
  - DONE: one cycle, then go to IDLE.
- Start (IDLE, i_start=1):
  - Latch op.
  - Latch |rs1| and |rs2|. Magnitudes are taken only for the operands that are signed for this op.
  - neg = signed sign(rs1) XOR signed sign(rs2). An operand treated as unsigned contributes sign 0.
  - P[63:0] = {32'h0, |rs2|}; cnt = 0.
- CALC iteration:
  - {c, s} = P[63:32] + (P[0] ? |rs1| : 0), computed by FA_32bit with cin = 0.
  - P = {c, s, P[31:1]}; cnt++.
  - Leave CALC after cnt reaches 31, i.e. after exactly 32 updates.
- FIX:
  - If neg, P = ~P + 1 (64-bit).
  - o_result = (op == MUL) ? P[31:0] : P[63:32].
- Arithmetic rules:
  - |0x80000000| = 0x80000000, which is representable as an unsigned 32-bit value.
  - A zero product with neg=1 negates to 0.
- i_start in CALC, FIX or DONE is ignored and is not queued. The core must re-issue it after o_done.
- Back-to-back operation: i_start may be high in the cycle after o_done (state IDLE).

## Timing
- Start accepted at edge N.
- CALC updates on edges N+1 .. N+32.
- FIX registers o_result on edge N+33.
- o_done high for the single cycle between edges N+33 and N+34. o_result is valid in that cycle.
- o_busy rises after edge N and falls after edge N+34.
- Reset: i_reset=0 at any edge forces:
  - state IDLE, cnt 0, P 0, neg 0;
  - o_result 0, o_busy 0, o_done 0.
- Reset mid-operation abandons the operation with no o_done pulse. o_result returns to 0.
- Operands and i_op are used only at the start edge; later changes have no effect.

## Structure
- Package mul_pkg holds:
  - enum mul_op_e {MUL, MULH, MULHSU, MULHU} (2-bit);
  - enum mul_state_e {IDLE, CALC, FIX, DONE};
  - localparams XLEN = 32 and ITER = 32.
- One sub-module: FA_32bit, instantiated once for the accumulate add. Its cout is c.
- The 64-bit negation in FIX is inline logic.

## Test plan
- MUL 7 × 6 → o_done exactly 33 edges after the start edge; o_result = 0x0000002A; o_busy high for 34 cycles.
- MUL 0xFFFFFFFD (−3) × 5 → 0xFFFFFFF1. MULH on the same operands → 0xFFFFFFFF.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MUL on the same operands → 0x00000000.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- MULH 0 × 0x80000000 → 0x00000000 (zero product with neg=1).
- Control sequence:
  - i_start pulsed at cycle 5 of CALC → ignored; the first result is unchanged.
  - i_reset low at iteration 10 → next cycle o_busy=0, o_result=0, and no o_done pulse.
  - Fresh MULHU 3 × 4 → 0x00000000 on schedule.
